// File: rtl/branch_hazard_sequencer_pkg.sv
// ============================================================================
//  Module : branch_hazard_sequencer_pkg
//  Brief  : Shared opcodes, FSM state encoding and hazard-match helper for
//           the ID-stage branch hazard sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_hazard_sequencer_pkg;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_BGEZ = 6'b000001;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic hazard_match(input logic [4:0] src,
                                          input logic [4:0] regd,
                                          input logic       regwrite);
        return regwrite && (regd == src) && (regd != 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_hazard_sequencer_detect.sv
// ============================================================================
//  Module : branch_hazard_detect
//  Brief  : Combinational branch decode and required-stall computation.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_hazard_detect
    import branch_hazard_sequencer_pkg::*;
#(
    parameter int unsigned ALU_EX_STALL   = 1,
    parameter int unsigned LOAD_EX_STALL  = 2,
    parameter int unsigned LOAD_MEM_STALL = 1,
    parameter int unsigned STALL_W        = 2
) (
    input  logic [15:0]        if_id_ins_hi,
    input  logic               if_id_valid,
    input  logic [4:0]         id_ex_regd,
    input  logic               id_ex_regwrite,
    input  logic               id_ex_memread,
    input  logic [4:0]         ex_mem_regd,
    input  logic               ex_mem_regwrite,
    input  logic               ex_mem_memread,
    output logic               is_br,
    output logic [STALL_W-1:0] stall_n
);

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_reads_rt;
    logic       w_reads_rs_only;
    logic       w_ex_hit;
    logic       w_mem_hit;

    assign w_opcode = if_id_ins_hi[15:10];
    assign w_rs     = if_id_ins_hi[9:5];
    assign w_rt     = if_id_ins_hi[4:0];

    assign w_reads_rt      = (w_opcode == OP_BEQ)  || (w_opcode == OP_BNE);
    assign w_reads_rs_only = (w_opcode == OP_BGTZ) || (w_opcode == OP_BGEZ);
    assign is_br           = if_id_valid && (w_reads_rt || w_reads_rs_only);

    // rt is a don't-care field for the single-operand branches.
    assign w_ex_hit  = hazard_match(w_rs, id_ex_regd, id_ex_regwrite) ||
                       (w_reads_rt && hazard_match(w_rt, id_ex_regd, id_ex_regwrite));
    assign w_mem_hit = hazard_match(w_rs, ex_mem_regd, ex_mem_regwrite) ||
                       (w_reads_rt && hazard_match(w_rt, ex_mem_regd, ex_mem_regwrite));

    always_comb begin
        stall_n = '0;
        if (is_br) begin
            if (w_ex_hit && id_ex_memread) begin
                stall_n = STALL_W'(LOAD_EX_STALL);
            end else if (w_ex_hit) begin
                stall_n = STALL_W'(ALU_EX_STALL);
            end else if (w_mem_hit && ex_mem_memread) begin
                stall_n = STALL_W'(LOAD_MEM_STALL);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_hazard_sequencer.sv
// ============================================================================
//  Module : branch_hazard_sequencer
//  Brief  : Stalls ID-stage branches until operands are forwardable, then
//           redirects the PC. Optional counters under `BRANCH_STATS_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_hazard_sequencer
    import branch_hazard_sequencer_pkg::*;
#(
    parameter int unsigned ALU_EX_STALL   = 1,
    parameter int unsigned LOAD_EX_STALL  = 2,
    parameter int unsigned LOAD_MEM_STALL = 1,
    parameter int unsigned STALL_W        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_id_ins,
    input  logic        if_id_valid,
    input  logic [4:0]  id_ex_regd,
    input  logic        id_ex_regwrite,
    input  logic        id_ex_memread,
    input  logic [4:0]  ex_mem_regd,
    input  logic        ex_mem_regwrite,
    input  logic        ex_mem_memread,
    input  logic        branch,
    input  logic [31:0] branch_address,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        busy
`ifdef BRANCH_STATS_EN
   ,output logic [31:0] stat_branches,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall_cycles
`endif
);

    localparam logic [STALL_W-1:0] C_CNT_ONE = STALL_W'(1);

    state_e             state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic               w_is_br;
    logic [STALL_W-1:0] w_stall_n;
    logic [STALL_W-1:0] w_stall_rem;
    logic               w_need_stall;
    logic               w_resolve;
    logic               unused_ins_lo;

    assign unused_ins_lo = ^if_id_ins[15:0];

    branch_hazard_detect #(
        .ALU_EX_STALL   (ALU_EX_STALL),
        .LOAD_EX_STALL  (LOAD_EX_STALL),
        .LOAD_MEM_STALL (LOAD_MEM_STALL),
        .STALL_W        (STALL_W)
    ) u_detect (
        .if_id_ins_hi    (if_id_ins[31:16]),
        .if_id_valid     (if_id_valid),
        .id_ex_regd      (id_ex_regd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_regd     (ex_mem_regd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_memread  (ex_mem_memread),
        .is_br           (w_is_br),
        .stall_n         (w_stall_n)
    );

    assign w_need_stall = (state_q == IDLE) && w_is_br && (w_stall_n != '0);
    assign w_resolve    = (state_q == IDLE) && w_is_br && (w_stall_n == '0);
    // The current cycle is already the first stall cycle.
    assign w_stall_rem  = w_stall_n - C_CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_need_stall) begin
                    cnt_d   = w_stall_rem;
                    state_d = (w_stall_rem == '0) ? IDLE : STALL;
                end
            end
            STALL: begin
                if (cnt_q <= C_CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pc_sel       = 1'b0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_need_stall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (w_resolve) begin
                    pc_sel      = branch;
                    if_id_flush = branch;
                end
            end
            STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_target = branch_address;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_stall_cycles_q, stat_stall_cycles_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q     <= '0;
            stat_taken_q        <= '0;
            stat_stall_cycles_q <= '0;
        end else begin
            stat_branches_q     <= stat_branches_d;
            stat_taken_q        <= stat_taken_d;
            stat_stall_cycles_q <= stat_stall_cycles_d;
        end
    end

    // All three counters stick at all-ones instead of wrapping.
    always_comb begin
        stat_branches_d     = stat_branches_q;
        stat_taken_d        = stat_taken_q;
        stat_stall_cycles_d = stat_stall_cycles_q;
        if (w_resolve && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (w_resolve && branch && (stat_taken_q != 32'hFFFF_FFFF)) begin
            stat_taken_d = stat_taken_q + 32'd1;
        end
        if (id_ex_bubble && (stat_stall_cycles_q != 32'hFFFF_FFFF)) begin
            stat_stall_cycles_d = stat_stall_cycles_q + 32'd1;
        end
    end

    assign stat_branches     = stat_branches_q;
    assign stat_taken        = stat_taken_q;
    assign stat_stall_cycles = stat_stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_sequencer.sv
// ============================================================================
//  Module : tb_branch_hazard_sequencer
//  Brief  : Self-checking bench for branch_hazard_sequencer (scoreboard queue).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_hazard_sequencer;

    typedef struct packed {
        logic        pw;
        logic        iw;
        logic        bub;
        logic        fl;
        logic        sel;
        logic        bsy;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_id_ins;
    logic        if_id_valid;
    logic [4:0]  id_ex_regd;
    logic        id_ex_regwrite;
    logic        id_ex_memread;
    logic [4:0]  ex_mem_regd;
    logic        ex_mem_regwrite;
    logic        ex_mem_memread;
    logic        branch;
    logic [31:0] branch_address;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        busy;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
    logic [31:0] stat_stall_cycles;
`endif

    exp_t exp_q[$];
    exp_t e;
    exp_t obs;
    int   n_checks = 0;
    int   n_fail   = 0;

    assign obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_sel, busy, pc_target};

    always #5 clk = ~clk;

    branch_hazard_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_ins       (if_id_ins),
        .if_id_valid     (if_id_valid),
        .id_ex_regd      (id_ex_regd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_regd     (ex_mem_regd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_memread  (ex_mem_memread),
        .branch          (branch),
        .branch_address  (branch_address),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .pc_sel          (pc_sel),
        .pc_target       (pc_target),
        .busy            (busy)
`ifdef BRANCH_STATS_EN
       ,.stat_branches     (stat_branches),
        .stat_taken        (stat_taken),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    function automatic logic [31:0] mk_ins(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    function automatic exp_t mk_exp(input logic pw, input logic iw, input logic bub,
                                    input logic fl, input logic sel, input logic bsy,
                                    input logic [31:0] tgt);
        return {pw, iw, bub, fl, sel, bsy, tgt};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic vld,
                         input logic [4:0] exd, input logic exw, input logic exm,
                         input logic [4:0] memd, input logic memw, input logic memm,
                         input logic br, input logic [31:0] addr);
        if_id_ins       = ins;
        if_id_valid     = vld;
        id_ex_regd      = exd;
        id_ex_regwrite  = exw;
        id_ex_memread   = exm;
        ex_mem_regd     = memd;
        ex_mem_regwrite = memw;
        ex_mem_memread  = memm;
        branch          = br;
        branch_address  = addr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, e);
        end
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_branches, stat_taken, stat_stall_cycles} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0",
                     stat_branches, stat_taken, stat_stall_cycles);
        end
`endif
        next_cycle();
    endtask

    task automatic test_resolve_taken();
        drive(mk_ins(6'b000100, 5'd1, 5'd2), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0040_0040);
        exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0040));
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL resolve_taken: got %h want %h", obs, e);
        end
        next_cycle();
    endtask

    task automatic test_alu_stall();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0: begin
                    drive(mk_ins(6'b000101, 5'd3, 5'd4), 1, 5'd3, 1, 0, 5'd0, 0, 0, 0, 32'h0040_0100);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 0, 32'h0040_0100));
                end
                default: begin
                    drive(mk_ins(6'b000101, 5'd3, 5'd4), 1, 5'd0, 0, 0, 5'd3, 1, 0, 0, 32'h0040_0100);
                    exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0040_0100));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL alu_stall cyc%0d: got %h want %h", i, obs, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_stall();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd5, 1, 1, 5'd0, 0, 0, 1, 32'h0040_0200);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 0, 32'h0040_0200));
                end
                1: begin
                    drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd0, 0, 0, 5'd5, 1, 1, 1, 32'h0040_0200);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 1, 32'h0040_0200));
                end
                default: begin
                    drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0040_0200);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0200));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_stall cyc%0d: got %h want %h", i, obs, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_rs_only();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    drive(mk_ins(6'b000111, 5'd7, 5'd0), 1, 5'd0, 1, 1, 5'd0, 0, 0, 1, 32'h0040_0300);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0300));
                end
                1: begin
                    drive(mk_ins(6'b000001, 5'd8, 5'd7), 1, 5'd7, 1, 1, 5'd7, 1, 1, 0, 32'h0040_0304);
                    exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0040_0304));
                end
                2: begin
                    drive(mk_ins(6'b000001, 5'd8, 5'd7), 1, 5'd0, 0, 0, 5'd8, 1, 1, 1, 32'h0040_0308);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 0, 32'h0040_0308));
                end
                default: begin
                    drive(mk_ins(6'b000001, 5'd8, 5'd7), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0040_0308);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0308));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rs_only cyc%0d: got %h want %h", i, obs, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd5, 1, 1, 5'd0, 0, 0, 1, 32'h0040_0400);
        next_cycle();
        // Asserted between edges: only an asynchronous reset clears STALL before negedge.
        rst_n = 1'b0;
        drive(mk_ins(6'b000100, 5'd5, 5'd6), 0, 5'd0, 0, 0, 5'd5, 1, 1, 1, 32'h0040_0400);
        exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0040_0400));
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h want %h", obs, e);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd5, 1, 1, 5'd0, 0, 0, 1, 32'h0040_0400);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 0, 32'h0040_0400));
                end
                1: begin
                    drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd0, 0, 0, 5'd5, 1, 1, 1, 32'h0040_0400);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 1, 32'h0040_0400));
                end
                default: begin
                    drive(mk_ins(6'b000100, 5'd5, 5'd6), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0040_0400);
                    exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0040_0400));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL restart_stall cyc%0d: got %h want %h", i, obs, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin
                    drive(mk_ins(6'b000100, 5'd1, 5'd2), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0040_0500);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0500));
                end
                1: begin
                    drive(mk_ins(6'b000101, 5'd2, 5'd1), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0040_0504);
                    exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0040_0504));
                end
                2: begin
                    drive(mk_ins(6'b000100, 5'd0, 5'd0), 1, 5'd0, 1, 1, 5'd0, 1, 1, 1, 32'h0040_0508);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0508));
                end
                3: begin
                    drive(mk_ins(6'b000100, 5'd9, 5'd10), 0, 5'd9, 1, 1, 5'd0, 0, 0, 1, 32'h0040_050C);
                    exp_q.push_back(mk_exp(1, 1, 0, 0, 0, 0, 32'h0040_050C));
                end
                4: begin
                    drive(mk_ins(6'b000100, 5'd9, 5'd10), 1, 5'd0, 0, 0, 5'd10, 1, 0, 1, 32'h0040_0510);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0510));
                end
                5: begin
                    drive(mk_ins(6'b000100, 5'd9, 5'd10), 1, 5'd0, 0, 0, 5'd10, 1, 1, 1, 32'h0040_0514);
                    exp_q.push_back(mk_exp(0, 0, 1, 0, 0, 0, 32'h0040_0514));
                end
                default: begin
                    drive(mk_ins(6'b000100, 5'd9, 5'd10), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0040_0514);
                    exp_q.push_back(mk_exp(1, 1, 0, 1, 1, 0, 32'h0040_0514));
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, e);
            end
            next_cycle();
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(mk_ins(6'b000100, 5'd1, 5'd2), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0040_0600);
                1: drive(mk_ins(6'b000101, 5'd3, 5'd4), 1, 5'd3, 1, 0, 5'd0, 0, 0, 0, 32'h0040_0604);
                2: drive(mk_ins(6'b000101, 5'd3, 5'd4), 1, 5'd0, 0, 0, 5'd3, 1, 0, 0, 32'h0040_0604);
                3: drive(mk_ins(6'b000101, 5'd3, 5'd4), 1, 5'd4, 1, 0, 5'd0, 0, 0, 0, 32'h0040_0608);
                4: drive(mk_ins(6'b000101, 5'd3, 5'd4), 1, 5'd0, 0, 0, 5'd4, 1, 0, 0, 32'h0040_0608);
                default: drive(32'h0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0);
            endcase
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (stat_branches !== 32'd3) begin
            n_fail++;
            $display("FAIL stat_branches: got %0d want 3", stat_branches);
        end
        n_checks++;
        if (stat_taken !== 32'd1) begin
            n_fail++;
            $display("FAIL stat_taken: got %0d want 1", stat_taken);
        end
        n_checks++;
        if (stat_stall_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL stat_stall_cycles: got %0d want 2", stat_stall_cycles);
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_resolve_taken();
        test_alu_stall();
        test_load_stall();
        test_rs_only();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_hazard_sequencer.md
Name: branch_hazard_sequencer

Overview:
- Sequences ID-stage branch resolution in the 5-stage MIPS pipeline.
- Detects when a branch in IF/ID reads a register whose value is not yet forwardable. In that case it stalls PC and IF/ID and injects ID/EX bubbles for a counted number of cycles.
- Once operands are valid, it samples the branch comparator's decision and drives PC redirect plus IF/ID flush.

Parameters:
- ALU_EX_STALL, 1, stall cycles when the source is produced by a non-load in ID/EX.
- LOAD_EX_STALL, 2, stall cycles when the source is produced by a load in ID/EX.
- LOAD_MEM_STALL, 1, stall cycles when the source is produced by a load in EX/MEM.
- STALL_W, 2, stall counter width; must hold the largest stall value.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_id_ins  in  32  instruction in IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction.
- id_ex_regd  in  5  ID/EX destination register.
- id_ex_regwrite  in  1  ID/EX writes a register.
- id_ex_memread  in  1  ID/EX is a load.
- ex_mem_regd  in  5  EX/MEM destination register.
- ex_mem_regwrite  in  1  EX/MEM writes a register.
- ex_mem_memread  in  1  EX/MEM is a load.
- branch  in  1  taken decision from the branch comparator.
- branch_address  in  32  target from the branch comparator.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID update enable.
- id_ex_bubble  out  1  force ID/EX control to NOP.
- if_id_flush  out  1  clear IF/ID at the next edge.
- pc_sel  out  1  1 selects pc_target over PC+4.
- pc_target  out  32  redirect address.
- busy  out  1  sequencer in STALL.

Behaviour:
- Branch decode: opcode 000100 (beq) or 000101 (bne) reads rs [25:21] and rt [20:16]; opcode 000111 (bgtz) or 000001 (bgez) reads rs only.
  - is_br = if_id_valid & opcode match.
- Hazard match: a source matches a stage only if regwrite=1 and regd equals the source and regd≠0.
- Required stall n, computed combinationally in IDLE; first matching rule wins:
  - ID/EX match with memread=1: n=LOAD_EX_STALL.
  - ID/EX match with memread=0: n=ALU_EX_STALL.
  - EX/MEM match with memread=1: n=LOAD_MEM_STALL.
  - Otherwise: n=0.
- States: IDLE, STALL.
- IDLE, is_br with n>0:
  - Outputs this cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Next edge: cnt<=n-1, go to STALL (the first stall cycle is the current one).
  - If n-1=0, stay in IDLE; the hazard is re-evaluated next cycle against the advanced pipeline.
- IDLE, is_br with n=0 (resolve cycle):
  - pc_write=1, if_id_write=1, id_ex_bubble=0.
  - pc_sel=branch; pc_target=branch_address; if_id_flush=branch.
- IDLE, no branch: pc_write=1, if_id_write=1, id_ex_bubble=0, pc_sel=0, if_id_flush=0.
- STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, pc_sel=0, if_id_flush=0, busy=1.
  - cnt decrements each cycle; at cnt=1 go to IDLE, cnt<=0.
  - Hazard inputs are ignored while in STALL.
- After returning to IDLE, hazard detection re-runs. A residual hazard (load moved EX→MEM) yields more stall; no hazard yields the resolve cycle.
- pc_target is always driven with branch_address; only pc_sel qualifies it.
- if_id_valid=0 is never a branch, including while in STALL.
- Reset (async, any state, including mid-STALL): state=IDLE, cnt=0.
  - Output values follow the IDLE/no-branch row: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pc_sel=0, busy=0.
- Register 0 never causes a stall.
- A single branch never stalls more than LOAD_EX_STALL cycles total.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds three 32-bit output ports, each reset to 0 and saturating at 0xFFFFFFFF:
  - stat_branches: increments on each resolve cycle.
  - stat_taken: increments on resolve cycles with branch=1.
  - stat_stall_cycles: increments on every cycle with id_ex_bubble=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode constants OP_BEQ, OP_BNE, OP_BGTZ, OP_BGEZ.
  - state enum {IDLE, STALL}.
- One sub-module, branch_hazard_detect: combinational is_br / n computation. The FSM and counter stay in the top module.

Test Plan:
- beq $1,$2 with no producers in flight, branch=1, branch_address=0x00400040 -> same cycle pc_sel=1, pc_target=0x00400040, if_id_flush=1, no stall.
- bne $3,$4 with id_ex_regd=3, regwrite=1, memread=0 -> exactly 1 bubble cycle, then resolve; branch=0 gives pc_sel=0.
- beq $5,$6 with id_ex load to $5 -> 2 cycles of pc_write=0 and id_ex_bubble=1, busy high in the second, then resolve.
- bgtz $7 with id_ex_regd=0 (regwrite=1), plus rt field=7 on a bgez with an EX/MEM load to $7 -> zero stalls for both; rt is ignored for bgtz/bgez.
- rst_n low for 1 cycle in the middle of a 2-cycle stall -> immediate IDLE outputs; a re-presented branch restarts stall counting from 2.
- With BRANCH_STATS_EN: 3 branches (1 taken, 2 stalls total) -> stat_branches=3, stat_taken=1, stat_stall_cycles=2.
